// File: rtl/flop_pkg.sv
// Shared types and constants for the multi-cycle single-precision subtractor.
package flop_pkg;

    localparam int          MANT_W  = 24;
    localparam logic [31:0] QNAN    = 32'h7FC00000;
    localparam logic [7:0]  EXP_MAX = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        UNPACK,
        ALIGN,
        OP,
        NORM,
        DONE
    } state_t;

endpackage

// File: rtl/flop_sub_seq_if.sv
// Operand/result handshake bundle between the subtractor and its producer/consumer.
interface flop_sub_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] minuend;
    logic [31:0] subtrahend;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        nan_flag;
    logic        ovf_flag;

    modport master (
        output in_valid, minuend, subtrahend, out_ready,
        input  in_ready, out_valid, result, nan_flag, ovf_flag
    );

    modport slave (
        input  in_valid, minuend, subtrahend, out_ready,
        output in_ready, out_valid, result, nan_flag, ovf_flag
    );
endinterface

// File: rtl/flop_classify.sv
// Classifies one single-precision word; denormals count as zero.
module flop_classify
    import flop_pkg::*;
(
    input  logic [31:0] value,
    output logic        is_zero,
    output logic        is_inf,
    output logic        is_nan
);
    logic sign_unused;

    assign sign_unused = value[31];
    assign is_zero     = (value[30:23] == 8'h00);
    assign is_inf      = (value[30:23] == EXP_MAX) && (value[22:0] == 23'd0);
    assign is_nan      = (value[30:23] == EXP_MAX) && (value[22:0] != 23'd0);
endmodule

// File: rtl/flop_sub_seq.sv
// Multi-cycle A - B single-precision subtractor: serial alignment, truncating rounding.
module flop_sub_seq
    import flop_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    flop_sub_seq_if.slave bus
);
    state_t              state, next_state;
    logic [31:0]         a_reg, b_reg;
    logic                sign_a, sign_b, res_sign, shift_b;
    logic [7:0]          exp_res;
    logic [MANT_W-1:0]   mant_a, mant_b, mant_res;
    logic [4:0]          shift_cnt;
    logic [31:0]         result_reg;
    logic                nan_reg, ovf_reg;

    logic                a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
    logic                eff_sign_b;
    logic                special, special_nan;
    logic [31:0]         special_res;
    logic [7:0]          exp_a, exp_b, exp_diff;
    logic [4:0]          align_cnt;
    logic [MANT_W:0]     sum;
    logic [MANT_W-1:0]   diff;
    logic                a_ge_b;

    flop_classify u_class_a (.value(a_reg), .is_zero(a_zero), .is_inf(a_inf), .is_nan(a_nan));
    flop_classify u_class_b (.value(b_reg), .is_zero(b_zero), .is_inf(b_inf), .is_nan(b_nan));

    // Special-operand decode, alignment distance and mantissa arithmetic used by both processes.
    always_comb begin
        special     = 1'b0;
        special_nan = 1'b0;
        special_res = 32'd0;
        eff_sign_b  = ~b_reg[31];
        exp_a       = a_reg[30:23];
        exp_b       = b_reg[30:23];
        exp_diff    = (exp_a >= exp_b) ? (exp_a - exp_b) : (exp_b - exp_a);
        align_cnt   = (exp_diff > 8'd25) ? 5'd25 : exp_diff[4:0];
        sum         = {1'b0, mant_a} + {1'b0, mant_b};
        a_ge_b      = (mant_a >= mant_b);
        diff        = a_ge_b ? (mant_a - mant_b) : (mant_b - mant_a);

        if (a_nan || b_nan) begin
            special     = 1'b1;
            special_nan = 1'b1;
            special_res = QNAN;
        end else if (a_inf && b_inf && (a_reg[31] != eff_sign_b)) begin
            special     = 1'b1;
            special_nan = 1'b1;
            special_res = QNAN;
        end else if (a_inf) begin
            special     = 1'b1;
            special_res = {a_reg[31], EXP_MAX, 23'd0};
        end else if (b_inf) begin
            special     = 1'b1;
            special_res = {eff_sign_b, EXP_MAX, 23'd0};
        end else if (a_zero && b_zero) begin
            special     = 1'b1;
            special_res = 32'd0;
        end else if (b_zero) begin
            special     = 1'b1;
            special_res = a_reg;
        end else if (a_zero) begin
            special     = 1'b1;
            special_res = {eff_sign_b, b_reg[30:0]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:   if (bus.in_valid) next_state = UNPACK;
            UNPACK: begin
                if (special)             next_state = DONE;
                else if (exp_a == exp_b) next_state = OP;
                else                     next_state = ALIGN;
            end
            ALIGN:  if (shift_cnt == 5'd1) next_state = OP;
            OP: begin
                if (sign_a == sign_b)
                    next_state = (sum[MANT_W] && exp_res == 8'hFE) ? DONE : NORM;
                else
                    next_state = (diff == '0) ? DONE : NORM;
            end
            NORM:   if (mant_res[MANT_W-1] || exp_res == 8'd1) next_state = DONE;
            DONE:   if (bus.out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath: each state updates only the registers it owns; the result is written once on entry to DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg      <= '0;
            b_reg      <= '0;
            sign_a     <= 1'b0;
            sign_b     <= 1'b0;
            res_sign   <= 1'b0;
            shift_b    <= 1'b0;
            exp_res    <= '0;
            mant_a     <= '0;
            mant_b     <= '0;
            mant_res   <= '0;
            shift_cnt  <= '0;
            result_reg <= '0;
            nan_reg    <= 1'b0;
            ovf_reg    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    a_reg   <= bus.minuend;
                    b_reg   <= bus.subtrahend;
                    nan_reg <= 1'b0;
                    ovf_reg <= 1'b0;
                end
                UNPACK: begin
                    if (special) begin
                        result_reg <= special_res;
                        nan_reg    <= special_nan;
                    end else begin
                        mant_a    <= {1'b1, a_reg[22:0]};
                        mant_b    <= {1'b1, b_reg[22:0]};
                        sign_a    <= a_reg[31];
                        sign_b    <= eff_sign_b;
                        exp_res   <= (exp_a >= exp_b) ? exp_a : exp_b;
                        shift_b   <= (exp_a >= exp_b);
                        shift_cnt <= align_cnt;
                    end
                end
                ALIGN: begin
                    if (shift_b) mant_b <= mant_b >> 1;
                    else         mant_a <= mant_a >> 1;
                    shift_cnt <= shift_cnt - 5'd1;
                end
                OP: begin
                    if (sign_a == sign_b) begin
                        res_sign <= sign_a;
                        if (sum[MANT_W]) begin
                            if (exp_res == 8'hFE) begin
                                result_reg <= {sign_a, EXP_MAX, 23'd0};
                                ovf_reg    <= 1'b1;
                            end else begin
                                mant_res <= sum[MANT_W:1];
                                exp_res  <= exp_res + 8'd1;
                            end
                        end else begin
                            mant_res <= sum[MANT_W-1:0];
                        end
                    end else if (diff == '0) begin
                        result_reg <= 32'd0;
                    end else begin
                        mant_res <= diff;
                        res_sign <= a_ge_b ? sign_a : sign_b;
                    end
                end
                NORM: begin
                    if (mant_res[MANT_W-1])
                        result_reg <= {res_sign, exp_res, mant_res[22:0]};
                    else if (exp_res == 8'd1)
                        result_reg <= {res_sign, 31'd0};
                    else begin
                        mant_res <= mant_res << 1;
                        exp_res  <= exp_res - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.result    = result_reg;
    assign bus.nan_flag  = nan_reg;
    assign bus.ovf_flag  = ovf_reg;
endmodule

// File: tb/tb_flop_sub_seq.sv
// Directed-vector bench for flop_sub_seq: specials, arithmetic paths, backpressure and mid-flight reset.
module tb_flop_sub_seq;
    import flop_pkg::*;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        nan;
        logic        ovf;
        int          lat;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    flop_sub_seq_if bus ();

    flop_sub_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic do_txn(input logic [31:0] a, input logic [31:0] b, output int lat);
        @(negedge clk);
        bus.minuend    = a;
        bus.subtrahend = b;
        bus.in_valid   = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid   = 1'b0;
        bus.minuend    = 32'h0;
        bus.subtrahend = 32'h0;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_out();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset in_ready: got %b expected 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset out_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.result !== 32'h0) begin failures++; $display("[TB] FAIL reset result: got %h expected 00000000", bus.result); end
        checks++; if (bus.nan_flag !== 1'b0 || bus.ovf_flag !== 1'b0) begin failures++; $display("[TB] FAIL reset flags: got %b%b expected 00", bus.nan_flag, bus.ovf_flag); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_special();
        vec_t v [8];
        int   lat;
        v[0] = '{32'h7F800000, 32'h7F800000, 32'h7FC00000, 1'b1, 1'b0, 1};
        v[1] = '{32'h7F800001, 32'h3F800000, 32'h7FC00000, 1'b1, 1'b0, 1};
        v[2] = '{32'h7F800000, 32'hFF800000, 32'h7F800000, 1'b0, 1'b0, 1};
        v[3] = '{32'h3F800000, 32'h7F800000, 32'hFF800000, 1'b0, 1'b0, 1};
        v[4] = '{32'h00000000, 32'h40000000, 32'hC0000000, 1'b0, 1'b0, 1};
        v[5] = '{32'h40A00000, 32'h80000000, 32'h40A00000, 1'b0, 1'b0, 1};
        v[6] = '{32'h80000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1};
        v[7] = '{32'h00000001, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1};
        for (int i = 0; i < 8; i++) begin
            do_txn(v[i].a, v[i].b, lat);
            checks++; if (bus.result !== v[i].res) begin failures++; $display("[TB] FAIL special[%0d] result: got %h expected %h", i, bus.result, v[i].res); end
            checks++; if (bus.nan_flag !== v[i].nan) begin failures++; $display("[TB] FAIL special[%0d] nan_flag: got %b expected %b", i, bus.nan_flag, v[i].nan); end
            checks++; if (bus.ovf_flag !== v[i].ovf) begin failures++; $display("[TB] FAIL special[%0d] ovf_flag: got %b expected %b", i, bus.ovf_flag, v[i].ovf); end
            checks++; if (lat !== v[i].lat) begin failures++; $display("[TB] FAIL special[%0d] latency: got %0d expected %0d", i, lat, v[i].lat); end
            release_out();
        end
    endtask

    task automatic test_arith();
        vec_t v [10];
        int   lat;
        v[0] = '{32'h40400000, 32'h3F800000, 32'h40000000, 1'b0, 1'b0, 4};
        v[1] = '{32'h3F800000, 32'h40400000, 32'hC0000000, 1'b0, 1'b0, 4};
        v[2] = '{32'h3FC00000, 32'h3FA00000, 32'h3E800000, 1'b0, 1'b0, 5};
        v[3] = '{32'h3F800000, 32'h3F800000, 32'h00000000, 1'b0, 1'b0, 2};
        v[4] = '{32'h3F800000, 32'hBF800000, 32'h40000000, 1'b0, 1'b0, 3};
        v[5] = '{32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 1'b0, 1'b1, 2};
        v[6] = '{32'h4B000000, 32'h3F800000, 32'h4AFFFFFE, 1'b0, 1'b0, 27};
        v[7] = '{32'h4E800000, 32'h3F800000, 32'h4E800000, 1'b0, 1'b0, 28};
        v[8] = '{32'h80C00000, 32'h80800000, 32'h80000000, 1'b0, 1'b0, 3};
        v[9] = '{32'h3F800000, 32'hB3800000, 32'h3F800000, 1'b0, 1'b0, 27};
        for (int i = 0; i < 10; i++) begin
            do_txn(v[i].a, v[i].b, lat);
            checks++; if (bus.result !== v[i].res) begin failures++; $display("[TB] FAIL arith[%0d] result: got %h expected %h", i, bus.result, v[i].res); end
            checks++; if (bus.nan_flag !== v[i].nan) begin failures++; $display("[TB] FAIL arith[%0d] nan_flag: got %b expected %b", i, bus.nan_flag, v[i].nan); end
            checks++; if (bus.ovf_flag !== v[i].ovf) begin failures++; $display("[TB] FAIL arith[%0d] ovf_flag: got %b expected %b", i, bus.ovf_flag, v[i].ovf); end
            checks++; if (lat !== v[i].lat) begin failures++; $display("[TB] FAIL arith[%0d] latency: got %0d expected %0d", i, lat, v[i].lat); end
            release_out();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        do_txn(32'h40400000, 32'h3F800000, lat);
        checks++; if (lat !== 4) begin failures++; $display("[TB] FAIL bp latency: got %0d expected 4", lat); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            bus.in_valid   = 1'b1;
            bus.minuend    = 32'h7F800000;
            bus.subtrahend = 32'h7F800000;
            @(posedge clk);
            #1;
            checks++; if (bus.result !== 32'h40000000) begin failures++; $display("[TB] FAIL bp[%0d] result: got %h expected 40000000", c, bus.result); end
            checks++; if (bus.nan_flag !== 1'b0 || bus.ovf_flag !== 1'b0) begin failures++; $display("[TB] FAIL bp[%0d] flags: got %b%b expected 00", c, bus.nan_flag, bus.ovf_flag); end
            checks++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL bp[%0d] handshake: got in_ready=%b out_valid=%b expected 0 1", c, bus.in_ready, bus.out_valid); end
        end
        bus.in_valid = 1'b0;
        release_out();
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL bp release: got in_ready=%b out_valid=%b expected 1 0", bus.in_ready, bus.out_valid); end
    endtask

    task automatic test_back_to_back();
        int lat;
        do_txn(32'h3FC00000, 32'h3FA00000, lat);
        checks++; if (bus.result !== 32'h3E800000 || lat !== 5) begin failures++; $display("[TB] FAIL b2b first: got %h lat %0d expected 3E800000 lat 5", bus.result, lat); end
        release_out();
        do_txn(32'h3F800000, 32'hBF800000, lat);
        checks++; if (bus.result !== 32'h40000000 || lat !== 3) begin failures++; $display("[TB] FAIL b2b second: got %h lat %0d expected 40000000 lat 3", bus.result, lat); end
        release_out();
    endtask

    task automatic test_reset_mid_align();
        int lat;
        int seen_valid;
        @(negedge clk);
        bus.minuend    = 32'h4B000000;
        bus.subtrahend = 32'h3F800000;
        bus.in_valid   = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL midreset handshake: got in_ready=%b out_valid=%b expected 1 0", bus.in_ready, bus.out_valid); end
        checks++; if (bus.result !== 32'h0 || bus.nan_flag !== 1'b0 || bus.ovf_flag !== 1'b0) begin failures++; $display("[TB] FAIL midreset outputs: got %h %b%b expected 00000000 00", bus.result, bus.nan_flag, bus.ovf_flag); end
        @(negedge clk);
        rst = 1'b0;
        seen_valid = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid === 1'b1) seen_valid++;
        end
        checks++; if (seen_valid !== 0) begin failures++; $display("[TB] FAIL midreset discard: got %0d valid cycles expected 0", seen_valid); end
        do_txn(32'h40400000, 32'h3F800000, lat);
        checks++; if (bus.result !== 32'h40000000 || lat !== 4) begin failures++; $display("[TB] FAIL midreset follow-up: got %h lat %0d expected 40000000 lat 4", bus.result, lat); end
        release_out();
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.minuend    = 32'h0;
        bus.subtrahend = 32'h0;
        bus.out_ready  = 1'b0;
        test_reset();
        test_special();
        test_arith();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_align();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/flop_sub_seq.md
FLOP_SUB_SEQ -- requirements
Module: flop_sub_seq

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 in_valid  input  1  operand pair presented.
REQ-005 in_ready  output  1  block can accept operands; high only in IDLE.
REQ-006 minuend  input  32  IEEE-754 single-precision operand A.
REQ-007 subtrahend  input  32  IEEE-754 single-precision operand B.
REQ-008 out_valid  output  1  result available; high only in DONE.
REQ-009 out_ready  input  1  consumer accepts result.
REQ-010 result  output  32  single-precision A - B.
REQ-011 nan_flag  output  1  result is NaN (NaN input, or inf - inf of equal sign).
REQ-012 ovf_flag  output  1  finite operands overflowed to infinity.

Function
REQ-013 Accept on the clk edge where in_valid && in_ready; register both operands; go to UNPACK.
REQ-014 States: IDLE, UNPACK, ALIGN, OP, NORM, DONE; no other state is reachable.
REQ-015 UNPACK: classify each operand as zero (exp=0, denormals flushed), inf, NaN or normal; negate B's sign (effective add of A and -B).
REQ-016 Special results, UNPACK -> DONE in 1 cycle:
  - any NaN -> 0x7FC00000, nan_flag=1.
  - inf - inf, same sign -> 0x7FC00000, nan_flag=1.
  - inf - other operand -> the inf of its effective sign.
  - A - 0 -> A.
  - 0 - B -> B with sign inverted.
  - 0 - 0 -> +0.
REQ-017 Normal operands: insert hidden 1 into 24-bit mantissas; result exponent = larger exponent.
REQ-018 Equal exponents: go UNPACK -> OP.
REQ-019 Unequal exponents: ALIGN shifts the smaller-exponent mantissa right 1 bit per cycle for d = min(|eA-eB|, 25) cycles, then goes to OP.
REQ-020 OP, signs equal after negation: add; on carry, shift right 1 and increment exponent; exponent 255 -> signed inf, ovf_flag=1, go to DONE.
REQ-021 OP, signs differ: subtract smaller magnitude from larger; sign = sign of the larger magnitude.
REQ-022 OP, zero difference -> +0, go directly to DONE.
REQ-023 NORM: each cycle, if mantissa bit 23 is set go to DONE; else shift left 1 and decrement exponent.
REQ-024 NORM: if the exponent would reach 0 -> signed zero, go to DONE.
REQ-025 Rounding is truncation (no guard/round/sticky bits).
REQ-026 Latency from the accepting edge to out_valid:
  - specials: 1 cycle.
  - exact cancellation: 2+d cycles.
  - otherwise: 3+d+k cycles, k = normalization left shifts.
REQ-027 DONE: result and flags SHALL stay stable while out_valid && !out_ready.
REQ-028 DONE with out_ready=1 -> IDLE on the next edge; no accept in the same cycle (minimum one idle cycle between transactions).
REQ-029 in_valid SHALL be ignored outside IDLE; operands do not need to be held after acceptance.

Reset
REQ-030 rst SHALL immediately force IDLE, in_ready=1, out_valid=0, result=0, nan_flag=0, ovf_flag=0, in any state including mid-ALIGN or mid-NORM.
REQ-031 A transaction in flight at reset SHALL be discarded and produce no output.

Structure
REQ-032 Package flop_pkg SHALL hold the state enum, QNAN=32'h7FC00000, EXP_MAX=8'hFF and the 24-bit mantissa width constant.
REQ-033 Operand classification SHALL be a sub-module flop_classify (32-bit in; is_zero, is_inf, is_nan out), instantiated twice.

Verification
REQ-034 0x40400000 - 0x3F800000 (3.0-1.0) -> 0x40000000, out_valid 4 cycles after accept.
REQ-035 0x3F800000 - 0xBF800000 (1.0-(-1.0)) -> 0x40000000 via carry path, latency 3; 0x7F7FFFFF - 0xFF7FFFFF -> 0x7F800000, ovf_flag=1.
REQ-036 0x3FC00000 - 0x3FA00000 (1.5-1.25) -> 0x3E800000, k=2, latency 5; 0x3F800000 - 0x3F800000 -> 0x00000000, latency 2.
REQ-037 0x7F800000 - 0x7F800000 -> 0x7FC00000, nan_flag=1, latency 1; 0x00000000 - 0x40000000 -> 0xC0000000.
REQ-038 Backpressure: hold out_ready=0 for 5 cycles -> result/flags unchanged, in_ready=0 throughout.
REQ-039 Reset during ALIGN (0x4B000000 - 0x3F800000) -> next cycle in_ready=1, out_valid=0; the following transaction completes correctly.
